threeby8_decoder_seq: RTL and testbench

Sequenced 3-to-8 one-hot decoder and the companion of the 8-to-3 priority encoder: it takes a 3-bit index over a valid/ready handshake and drives the matching one-hot line `y` for a programmable number of cycles. A one-cycle all-zero gap follows every pulse, so two lines are never active together (break-before-make). A one-entry pending buffer allows back-to-back requests. Typical use: line-select / strobe generation downstream of encoded requests.

---
 rtl/threeby8_decoder_seq.sv | 142 ++++++++++++++
 tb/tb_threeby8_decoder_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/threeby8_decoder_seq.sv
// Sequenced 3-to-8 one-hot decoder: each accepted code drives y for HOLD_CYCLES, then one all-zero GAP cycle with done.
// Output one cycle after accept; one-entry pending buffer, in_ready = en && !pend_valid.
module threeby8_decoder_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] code,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CW-1:0] LP_RELOAD = CW'(HOLD_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cur_code;
    logic [2:0]      w_cur_code_nxt;
    logic [2:0]      r_pend_code;
    logic            r_pend_valid;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_accept;
    logic            w_pend_write;
    logic            w_pend_take;
    logic [7:0]      r_y;
    logic [7:0]      w_y_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_done;
    logic            w_done_nxt;

    assign in_ready     = en && !r_pend_valid;
    assign w_accept     = in_valid && in_ready;
    // Accepts outside IDLE park in the pending slot; IDLE accepts go straight to DRIVE.
    assign w_pend_write = w_accept && (r_state != S_IDLE);

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur_code <= 3'd0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_code <= w_cur_code_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_code_nxt = r_cur_code;
        w_cnt_nxt      = r_cnt;
        w_pend_take    = 1'b0;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A code written in the last GAP cycle is picked up here, one cycle late.
                    if (r_pend_valid) begin
                        w_pend_take    = 1'b1;
                        w_cur_code_nxt = r_pend_code;
                        w_cnt_nxt      = LP_RELOAD;
                        w_state_nxt    = S_DRIVE;
                    end else if (w_accept) begin
                        w_cur_code_nxt = code;
                        w_cnt_nxt      = LP_RELOAD;
                        w_state_nxt    = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_pend_valid) begin
                        w_pend_take    = 1'b1;
                        w_cur_code_nxt = r_pend_code;
                        w_cnt_nxt      = LP_RELOAD;
                        w_state_nxt    = S_DRIVE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_y_nxt    = 8'd0;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_GAP);
        if (w_state_nxt == S_DRIVE) begin
            w_y_nxt = 8'd1 << w_cur_code_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y    <= 8'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_y    <= w_y_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_pend_valid <= 1'b0;
            r_pend_code  <= 3'd0;
        end else if (w_pend_write) begin
            r_pend_valid <= 1'b1;
            r_pend_code  <= code;
        end else if (w_pend_take) begin
            r_pend_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_threeby8_decoder_seq.sv
// Bench for threeby8_decoder_seq: scoreboard of accepted codes checked against pulses on y, plus directed corner sequences.
module tb_threeby8_decoder_seq;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] code;
    logic [7:0] y;
    logic       busy;
    logic       done;

    threeby8_decoder_seq #(.HOLD_CYCLES(HOLD), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .code     (code),
        .y        (y),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic [2:0] c;
    } exp_t;

    typedef struct {
        logic [2:0] code;
        logic [7:0] y;
        logic [2:0] enc;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       e_mon;
    vec_t       vec[8];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_done = 0;
    bit         no_len_chk = 1'b0;
    logic [7:0] prev_y = 8'd0;
    int         run_len = 0;

    function automatic logic [2:0] penc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic expect_out(input string nm, input logic [7:0] ey, input logic eb, input logic ed);
        chk({nm, "_y"}, 32'(y), 32'(ey));
        chk({nm, "_busy"}, 32'(busy), 32'(eb));
        chk({nm, "_done"}, 32'(done), 32'(ed));
    endtask

    // Called at a falling edge with inputs already set; records the handshake and moves one cycle on.
    task automatic step(input logic [7:0] ey, input logic [2:0] ec, output bit acc);
        #1;
        acc = in_valid && in_ready && !rst;
        if (acc) exp_q.push_back('{y: ey, c: ec});
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(8'd0, 3'd0, a);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (y !== 8'd0 && !$isunknown(y)) begin
            chk("onehot", 32'($onehot(y)), 32'd1);
            if (prev_y == 8'd0) begin
                run_len = 1;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pulse", 32'(y), 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("sb_y", 32'(y), 32'(e_mon.y));
                    chk("roundtrip", 32'(penc(y)), 32'(e_mon.c));
                end
            end else begin
                chk("break_before_make", 32'(y), 32'(prev_y));
                run_len++;
            end
        end else if (prev_y != 8'd0 && !no_len_chk) begin
            chk("pulse_len", 32'(run_len), 32'(HOLD));
            chk("done_at_gap", 32'(done), 32'd1);
        end
        prev_y = $isunknown(y) ? 8'd0 : y;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit         acc;
        int         d0;
        logic [7:0] bb_y [11];

        vec[0] = '{code: 3'd0, y: 8'h01, enc: 3'd0};
        vec[1] = '{code: 3'd1, y: 8'h02, enc: 3'd1};
        vec[2] = '{code: 3'd2, y: 8'h04, enc: 3'd2};
        vec[3] = '{code: 3'd3, y: 8'h08, enc: 3'd3};
        vec[4] = '{code: 3'd4, y: 8'h10, enc: 3'd4};
        vec[5] = '{code: 3'd5, y: 8'h20, enc: 3'd5};
        vec[6] = '{code: 3'd6, y: 8'h40, enc: 3'd6};
        vec[7] = '{code: 3'd7, y: 8'h80, enc: 3'd7};
        bb_y = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};

        // Reset with a live request on the inputs.
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; code = 3'd3;
        @(negedge clk);
        expect_out("rst1", 8'h00, 1'b0, 1'b0);
        step(8'h08, 3'd3, acc);
        expect_out("rst2", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step(8'h08, 3'd3, acc);
        in_valid = 1'b0;
        expect_out("first_accept", 8'h08, 1'b1, 1'b0);
        cyc(HOLD + 1);
        expect_out("first_idle", 8'h00, 1'b0, 1'b0);

        // Single pulse, code 5.
        in_valid = 1'b1; code = 3'd5;
        step(8'h20, 3'd5, acc);
        in_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            expect_out("single_drive", 8'h20, 1'b1, 1'b0);
            cyc(1);
        end
        expect_out("single_gap", 8'h00, 1'b1, 1'b1);
        cyc(1);
        expect_out("single_idle", 8'h00, 1'b0, 1'b0);

        // Back-to-back: 0 then 7 into the pending slot.
        d0 = n_done;
        in_valid = 1'b1; code = 3'd0;
        step(8'h01, 3'd0, acc);
        chk("bb_ready_n1", 32'(in_ready), 32'd1);
        expect_out("bb0", bb_y[0], 1'b1, 1'b0);
        code = 3'd7;
        step(8'h80, 3'd7, acc);
        in_valid = 1'b0;
        chk("bb_ready_low", 32'(in_ready), 32'd0);
        expect_out("bb1", bb_y[1], 1'b1, 1'b0);
        for (int i = 2; i < 11; i++) begin
            cyc(1);
            expect_out("bb_seq", bb_y[i], (i != 10), (i == 4 || i == 9));
            if (i == 5) chk("bb_ready_back", 32'(in_ready), 32'd1);
        end
        cyc(1);
        chk("bb_done_count", 32'(n_done - d0), 32'd2);

        // Sweep all codes with in_valid held high.
        d0 = n_done;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; code = vec[i].code; acc = 1'b0;
            for (int t = 0; t < 3 * HOLD + 4 && !acc; t++) step(vec[i].y, vec[i].enc, acc);
            if (!acc) chk("sweep_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        cyc(2 * (HOLD + 2));
        chk("sweep_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("sweep_done_count", 32'(n_done - d0), 32'd8);

        // Abort with a pending request: en drops in the third DRIVE cycle.
        no_len_chk = 1'b1;
        d0 = n_done;
        in_valid = 1'b1; code = 3'd2;
        step(8'h04, 3'd2, acc);
        code = 3'd6;
        step(8'h40, 3'd6, acc);
        in_valid = 1'b0;
        cyc(1);
        en = 1'b0;
        cyc(1);
        expect_out("abort", 8'h00, 1'b0, 1'b0);
        chk("abort_ready_en0", 32'(in_ready), 32'd0);
        en = 1'b1;
        cyc(1);
        chk("abort_ready_back", 32'(in_ready), 32'd1);
        cyc(HOLD + 2);
        expect_out("abort_quiet", 8'h00, 1'b0, 1'b0);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_pend_dropped", 32'(exp_q.size()), 32'd1);
        exp_q.delete();

        // Reset during DRIVE with a pending request.
        in_valid = 1'b1; code = 3'd4;
        step(8'h10, 3'd4, acc);
        code = 3'd1;
        step(8'h02, 3'd1, acc);
        in_valid = 1'b0; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        expect_out("rst_drive", 8'h00, 1'b0, 1'b0);
        chk("rst_drive_pend_clr", 32'(in_ready), 32'd1);
        cyc(HOLD + 2);
        chk("rst_drive_quiet", 32'(y), 32'd0);
        chk("rst_drive_sb", 32'(exp_q.size()), 32'd1);
        exp_q.delete();

        // Reset during GAP with a pending request.
        in_valid = 1'b1; code = 3'd3;
        step(8'h08, 3'd3, acc);
        code = 3'd6;
        step(8'h40, 3'd6, acc);
        in_valid = 1'b0;
        cyc(HOLD - 1);
        expect_out("gap_reached", 8'h00, 1'b1, 1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        expect_out("rst_gap", 8'h00, 1'b0, 1'b0);
        chk("rst_gap_pend_clr", 32'(in_ready), 32'd1);
        cyc(HOLD + 2);
        chk("rst_gap_quiet", 32'(y), 32'd0);
        chk("rst_gap_sb", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        no_len_chk = 1'b0;

        // Accept in the GAP cycle with pending empty: one IDLE cycle, then DRIVE.
        in_valid = 1'b1; code = 3'd1;
        step(8'h02, 3'd1, acc);
        in_valid = 1'b0;
        cyc(HOLD);
        expect_out("gapacc_gap", 8'h00, 1'b1, 1'b1);
        in_valid = 1'b1; code = 3'd5;
        step(8'h20, 3'd5, acc);
        in_valid = 1'b0;
        chk("gapacc_accepted", 32'(acc), 32'd1);
        expect_out("gapacc_idle", 8'h00, 1'b0, 1'b0);
        chk("gapacc_ready_low", 32'(in_ready), 32'd0);
        cyc(1);
        expect_out("gapacc_drive", 8'h20, 1'b1, 1'b0);
        cyc(HOLD + 2);
        expect_out("final_idle", 8'h00, 1'b0, 1'b0);
        chk("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
